// File: rtl/a2g_mailbox_pkg.sv
// -----------------------------------------------------------------------------
// a2g_mailbox_pkg
// Shared definitions for the OPB control mailbox: register word select,
// status word layout, flush control bit, OPB handshake FSM states and the
// status word packing helper.
// -----------------------------------------------------------------------------
package a2g_mailbox_pkg;

  // LSB-relative address bit that selects between the two decoded words
  // (offset 0x0 = DATA, offset 0x4 = STATUS).
  localparam int   WORD_SEL_BIT = 2;
  localparam logic WSEL_DATA    = 1'b0;
  localparam logic WSEL_STATUS  = 1'b1;

  // Status word bit positions, LSB-relative.
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_COUNT_LSB = 8;

  // Write-data bit (LSB-relative) of a STATUS write that requests a flush.
  localparam int FLUSH_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } opb_state_e;

  // Count is passed zero-extended to 9 bits; at the largest depth (256) its
  // MSB lands in bit 16 so a full FIFO still reports its true level.
  function automatic logic [31:0] status_word(input logic       empty,
                                              input logic       full,
                                              input logic       underflow,
                                              input logic [8:0] count);
    logic [31:0] w;
    w                   = '0;
    w[ST_EMPTY]         = empty;
    w[ST_FULL]          = full;
    w[ST_UNDERFLOW]     = underflow;
    w[ST_COUNT_LSB +: 9] = count;
    return w;
  endfunction

endpackage

// File: rtl/a2g_mailbox_fifo.sv
// -----------------------------------------------------------------------------
// a2g_mailbox_fifo
// Single-clock synchronous FIFO of 32-bit words, 2**DEPTH_LOG2 deep.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write head of the tail (caller guarantees !full)
//   pop               advance the head (caller guarantees !empty)
//   flush             empty the FIFO; overrides push and pop
//   head_data         oldest word (valid when !empty)
//   empty, full       derived from the registered count
//   count             registered fill level, 0..2**DEPTH_LOG2
// -----------------------------------------------------------------------------
module a2g_mailbox_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [31:0]         push_data,
  input  logic                pop,
  input  logic                flush,
  output logic [31:0]         head_data,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] count
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no branch can
    // leave a value unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      // Simultaneous push and pop leave the level unchanged.
      count_d = count_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign count     = count_q;

endmodule

// File: rtl/a2g_ctrl_mailbox.sv
// -----------------------------------------------------------------------------
// a2g_ctrl_mailbox
// OPB slave mailbox: NUM_REQ fabric requesters push 32-bit words through a
// round-robin arbiter into one FIFO; the PPC polls STATUS and pops DATA.
// Ports:
//   OPB_*            OPB slave inputs (BE and seqAddr are ignored)
//   Sl_*             OPB slave responses; xferAck is a single-cycle pulse and
//                    Sl_DBus is 0 outside the ack cycle
//   req_valid/data   per-requester word offer, held until acknowledged
//   req_ack          one-hot grant; the word is taken in that cycle
//   rx_full/count    registered FIFO fill status
// OPB buses use bit 0 = MSB; internally everything is LSB-relative.
// -----------------------------------------------------------------------------
module a2g_ctrl_mailbox
  import a2g_mailbox_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01002300,
  parameter logic [31:0] C_HIGHADDR = 32'h010023FF,
  parameter int          NUM_REQ    = 4,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic                    rx_full,
  output logic [DEPTH_LOG2:0]     rx_count
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // LSB-relative views of the OPB buses.
  logic [31:0] abus, wdata, rdata;
  assign abus  = OPB_ABus;
  assign wdata = OPB_DBus;

  logic unused_ok;
  assign unused_ok = ^{OPB_BE, OPB_seqAddr, wdata};

  logic addr_hit;
  assign addr_hit = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

  // ---------------------------------------------------------------- OPB FSM
  // Transfer attributes are captured when the hit is seen so the ack cycle
  // acts on exactly what the master presented.
  opb_state_e state_q;
  logic       rnw_q, word_sel_q, flush_req_q;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q     <= S_IDLE;
      rnw_q       <= 1'b0;
      word_sel_q  <= WSEL_DATA;
      flush_req_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (addr_hit) begin
          state_q     <= S_ACK;
          rnw_q       <= OPB_RNW;
          word_sel_q  <= abus[WORD_SEL_BIT];
          flush_req_q <= wdata[FLUSH_BIT];
        end
        S_ACK:  state_q <= S_WAIT;
        // Holding here until select drops prevents a second ack on a held select.
        S_WAIT: if (!OPB_select) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ FIFO + ack
  logic                  fifo_push, fifo_pop, fifo_flush;
  logic [31:0]           fifo_push_data, fifo_head;
  logic                  fifo_empty, fifo_full;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  ack_cycle, rd_data_word, underflow_set;
  logic                  underflow_q, underflow_d;

  a2g_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (OPB_Clk),
    .rst       (OPB_Rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_comb begin
    // A reset asserted in the ack cycle aborts the transfer without an ack.
    ack_cycle     = (state_q == S_ACK) && !OPB_Rst;
    rd_data_word  = ack_cycle && rnw_q && (word_sel_q == WSEL_DATA);
    fifo_pop      = rd_data_word && !fifo_empty;
    underflow_set = rd_data_word && fifo_empty;
    fifo_flush    = ack_cycle && !rnw_q && (word_sel_q == WSEL_STATUS) && flush_req_q;
    underflow_d   = fifo_flush ? 1'b0 : (underflow_q | underflow_set);

    rdata = '0;
    if (ack_cycle && rnw_q) begin
      if (word_sel_q == WSEL_STATUS)
        rdata = status_word(fifo_empty, fifo_full, underflow_q, 9'(fifo_count));
      else if (!fifo_empty)
        rdata = fifo_head;
    end
  end

  assign Sl_xferAck = ack_cycle;
  assign Sl_DBus    = rdata;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  // ------------------------------------------------------------- Arbiter
  // Full is the registered level, so a pop this cycle frees a slot only for
  // the next cycle's grant.
  logic [RR_W-1:0] rr_q, rr_d;
  logic            grant_found;
  int              arb_idx;

  always_comb begin
    req_ack        = '0;
    fifo_push      = 1'b0;
    fifo_push_data = '0;
    rr_d           = rr_q;
    grant_found    = 1'b0;
    arb_idx        = 0;
    if (!OPB_Rst && !fifo_full && !fifo_flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        arb_idx = (int'(rr_q) + k) % NUM_REQ;
        if (!grant_found && req_valid[arb_idx]) begin
          grant_found      = 1'b1;
          req_ack[arb_idx] = 1'b1;
          fifo_push        = 1'b1;
          fifo_push_data   = req_data[32*arb_idx +: 32];
          rr_d             = (arb_idx == NUM_REQ - 1) ? '0 : RR_W'(arb_idx + 1);
        end
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      rr_q        <= '0;
      underflow_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      underflow_q <= underflow_d;
    end
  end

  assign rx_full  = fifo_full;
  assign rx_count = fifo_count;

endmodule

// File: tb/tb_a2g_ctrl_mailbox.sv
// -----------------------------------------------------------------------------
// tb_a2g_ctrl_mailbox
// Directed and randomized stimulus for a2g_ctrl_mailbox. A queue-based model
// of the mailbox predicts every cycle's acknowledges, read data and fill level.
// -----------------------------------------------------------------------------
module tb_a2g_ctrl_mailbox;

  localparam logic [31:0] BASE       = 32'h01002300;
  localparam logic [31:0] HIGH       = 32'h010023FF;
  localparam int          NUM_REQ    = 4;
  localparam int          DEPTH_LOG2 = 4;
  localparam int          DEPTH      = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [31:0]           abus, dbus, sl_dbus;
  logic [3:0]            be;
  logic                  rnw, sel, seq_addr;
  logic                  err_ack, retry, tout_sup, xack;
  logic [NUM_REQ-1:0]    req_valid, req_ack;
  logic [NUM_REQ*32-1:0] req_data;
  logic                  rx_full;
  logic [DEPTH_LOG2:0]   rx_count;

  a2g_ctrl_mailbox #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .NUM_REQ(NUM_REQ), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr),
    .Sl_DBus(sl_dbus), .Sl_errAck(err_ack), .Sl_retry(retry), .Sl_toutSup(tout_sup),
    .Sl_xferAck(xack), .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .rx_full(rx_full), .rx_count(rx_count)
  );

  int checks = 0;
  int errors = 0;

  // Requester side: offers held until granted. Mode 0 drops after a grant,
  // mode 1 re-offers fresh data, mode 2 re-offers at random.
  bit          rv [NUM_REQ];
  logic [31:0] rd [NUM_REQ];
  int          req_mode;

  // Mailbox model.
  logic [31:0] q[$];
  int          m_rr;
  bit          m_uf, m_pend, m_busy, m_rnw, m_stat;
  logic [31:0] m_wdata;

  // Observations from the last step.
  logic              obs_xack;
  logic [31:0]       obs_dbus;
  logic [NUM_REQ-1:0] obs_req_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]         = rv[i];
      req_data[32*i +: 32] = rd[i];
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rr = 0; m_uf = 0; m_pend = 0; m_busy = 0;
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = q.size();
    return 32'((n << 8) + (int'(m_uf) << 2) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
  endfunction

  // One clock cycle: predict and compare at the falling edge, advance the
  // model at the rising edge, then update requesters just after it.
  task automatic step();
    logic [31:0]        e_dbus;
    logic [NUM_REQ-1:0] e_ack;
    bit                 do_pop, do_flush, do_uf, hit;
    int                 g;
    @(negedge clk);
    e_dbus = '0; e_ack = '0; do_pop = 0; do_flush = 0; do_uf = 0; g = -1;
    if (!rst && m_pend) begin
      if (m_rnw) begin
        if (m_stat)               e_dbus = exp_status();
        else if (q.size() > 0) begin e_dbus = q[0]; do_pop = 1; end
        else                      do_uf = 1;
      end else if (m_stat && m_wdata[0]) begin
        do_flush = 1;
      end
    end
    if (!rst && q.size() < DEPTH && !do_flush)
      for (int k = 0; k < NUM_REQ; k++) begin
        int i = (m_rr + k) % NUM_REQ;
        if (g < 0 && rv[i]) g = i;
      end
    if (g >= 0) e_ack[g] = 1'b1;
    obs_xack = xack; obs_dbus = sl_dbus; obs_req_ack = req_ack;
    chk("xferAck",  64'(xack),     64'(!rst && m_pend));
    chk("Sl_DBus",  64'(sl_dbus),  64'(e_dbus));
    chk("req_ack",  64'(req_ack),  64'(e_ack));
    chk("rx_full",  64'(rx_full),  64'(q.size() == DEPTH));
    chk("rx_count", 64'(rx_count), 64'(q.size()));
    hit = sel && (abus >= BASE) && (abus <= HIGH);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (do_flush) begin q.delete(); m_uf = 0; end
      if (do_pop)   void'(q.pop_front());
      if (do_uf)    m_uf = 1;
      if (g >= 0) begin q.push_back(rd[g]); m_rr = (g + 1) % NUM_REQ; end
      if (m_pend) begin
        m_pend = 0; m_busy = 1;
      end else if (m_busy) begin
        if (!sel) m_busy = 0;
      end else if (hit) begin
        m_pend = 1; m_rnw = rnw; m_stat = abus[2]; m_wdata = dbus;
      end
    end
    #1;
    if (g >= 0 && !rst) begin
      if (req_mode == 1) rd[g] = $urandom;
      else               rv[g] = 0;
    end
    if (req_mode == 2)
      for (int i = 0; i < NUM_REQ; i++)
        if (!rv[i] && $urandom_range(0, 3) == 0) begin rv[i] = 1; rd[i] = $urandom; end
    drive_reqs();
  endtask

  // One OPB transfer with select held for `hold` cycles, then one idle cycle.
  task automatic opb_xfer(input logic [31:0] addr, input bit rd_nwr, input logic [31:0] wd,
                          input int hold, output logic [31:0] rdata, output int n_ack,
                          output int first_ack, output logic [NUM_REQ-1:0] ack_cycle_req);
    abus = addr; rnw = rd_nwr; dbus = wd; sel = 1'b1;
    n_ack = 0; first_ack = -1; rdata = '0; ack_cycle_req = '0;
    for (int c = 0; c <= hold; c++) begin
      if (c == hold) sel = 1'b0;
      step();
      if (obs_xack) begin
        n_ack++;
        if (first_ack < 0) first_ack = c;
        rdata = obs_dbus;
        ack_cycle_req = obs_req_ack;
      end
    end
  endtask

  logic [31:0]        rdata;
  int                 n_ack, first_ack, bound, rst_acks;
  logic [NUM_REQ-1:0] ack_req;

  initial begin
    rst = 1'b1; sel = 1'b0; rnw = 1'b0; abus = '0; dbus = '0; be = 4'hF; seq_addr = 1'b0;
    req_mode = 0;
    for (int i = 0; i < NUM_REQ; i++) begin rv[i] = 0; rd[i] = '0; end
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    rst = 1'b0;
    step();

    // Reset state and tied responses.
    chk("reset_count",  64'(rx_count), 64'(0));
    chk("reset_full",   64'(rx_full),  64'(0));
    chk("reset_xack",   64'(xack),     64'(0));
    chk("reset_dbus",   64'(sl_dbus),  64'(0));
    chk("tied_errAck",  64'({err_ack, retry, tout_sup}), 64'(0));

    // STATUS after reset, select held 5 cycles: single ack, one cycle late.
    opb_xfer(BASE + 32'h4, 1'b1, '0, 5, rdata, n_ack, first_ack, ack_req);
    chk("status_after_reset", 64'(rdata),     64'(32'h1));
    chk("ack_latency",        64'(first_ack), 64'(1));
    chk("single_ack",         64'(n_ack),     64'(1));

    // Four simultaneous requesters are granted in order 0,1,2,3.
    for (int i = 0; i < NUM_REQ; i++) begin rv[i] = 1; rd[i] = 32'hA0 + 32'(i); end
    drive_reqs();
    for (int k = 0; k < NUM_REQ; k++) begin
      step();
      chk("rr_order", 64'(obs_req_ack), 64'(1 << k));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      opb_xfer(BASE, 1'b1, '0, 2, rdata, n_ack, first_ack, ack_req);
      chk("data_read_order", 64'(rdata), 64'(32'hA0 + 32'(k)));
    end
    opb_xfer(BASE + 32'h4, 1'b1, '0, 2, rdata, n_ack, first_ack, ack_req);
    chk("status_drained", 64'(rdata), 64'(32'h1));

    // Fill to full with all requesters continuously offering.
    req_mode = 1;
    for (int i = 0; i < NUM_REQ; i++) begin rv[i] = 1; rd[i] = $urandom; end
    drive_reqs();
    bound = 0;
    while (q.size() < DEPTH && bound < 64) begin step(); bound++; end
    chk("fill_full",   64'(rx_full),  64'(1));
    chk("fill_count",  64'(rx_count), 64'(DEPTH));
    chk("full_no_ack", 64'(req_ack),  64'(0));
    opb_xfer(BASE + 32'h4, 1'b1, '0, 2, rdata, n_ack, first_ack, ack_req);
    chk("status_full", 64'(rdata), 64'(32'h00001002));
    opb_xfer(BASE, 1'b1, '0, 2, rdata, n_ack, first_ack, ack_req);
    chk("no_push_in_pop_cycle", 64'(ack_req),  64'(0));
    chk("refill_after_pop",     64'(rx_count), 64'(DEPTH));

    // Flush twice; the second lands while requesters offer and FIFO has room.
    opb_xfer(BASE + 32'h4, 1'b0, 32'h1, 2, rdata, n_ack, first_ack, ack_req);
    opb_xfer(BASE + 32'h4, 1'b0, 32'h1, 2, rdata, n_ack, first_ack, ack_req);
    chk("flush_wins", 64'(ack_req), 64'(0));
    req_mode = 0;
    repeat (8) step();
    opb_xfer(BASE + 32'h4, 1'b0, 32'h1, 2, rdata, n_ack, first_ack, ack_req);
    chk("flushed_count", 64'(rx_count), 64'(0));

    // Underflow on an empty DATA read, cleared by a flush.
    opb_xfer(BASE, 1'b1, '0, 2, rdata, n_ack, first_ack, ack_req);
    chk("empty_read_data", 64'(rdata), 64'(0));
    chk("empty_read_ack",  64'(n_ack), 64'(1));
    opb_xfer(BASE + 32'h4, 1'b1, '0, 2, rdata, n_ack, first_ack, ack_req);
    chk("status_underflow", 64'(rdata), 64'(32'h5));
    opb_xfer(BASE + 32'h4, 1'b0, 32'h1, 2, rdata, n_ack, first_ack, ack_req);
    opb_xfer(BASE + 32'h4, 1'b1, '0, 2, rdata, n_ack, first_ack, ack_req);
    chk("status_uf_cleared", 64'(rdata), 64'(32'h1));

    // Push and pop in the same cycle at a level of 5.
    for (int k = 0; k < 5; k++) begin rv[0] = 1; rd[0] = 32'h500 + 32'(k); drive_reqs(); step(); end
    chk("level_five", 64'(rx_count), 64'(5));
    abus = BASE; rnw = 1'b1; sel = 1'b1;
    step();
    rv[2] = 1; rd[2] = 32'hBEEF; drive_reqs();
    step();
    chk("pushpop_ack",   64'(obs_xack),    64'(1));
    chk("pushpop_data",  64'(obs_dbus),    64'(32'h500));
    chk("pushpop_grant", 64'(obs_req_ack), 64'(4'b0100));
    chk("pushpop_count", 64'(rx_count),    64'(5));
    sel = 1'b0;
    step();

    // Reset while the OPB FSM waits with words queued.
    opb_xfer(BASE + 32'h4, 1'b0, 32'h1, 2, rdata, n_ack, first_ack, ack_req);
    for (int k = 0; k < 3; k++) begin rv[1] = 1; rd[1] = 32'h600 + 32'(k); drive_reqs(); step(); end
    abus = BASE + 32'h4; rnw = 1'b1; sel = 1'b1;
    repeat (3) step();
    chk("queued_three", 64'(rx_count), 64'(3));
    rst = 1'b1; sel = 1'b0;
    rst_acks = 0;
    repeat (2) begin step(); if (obs_xack) rst_acks++; end
    rst = 1'b0;
    chk("no_ack_in_reset", 64'(rst_acks), 64'(0));
    opb_xfer(BASE + 32'h4, 1'b1, '0, 2, rdata, n_ack, first_ack, ack_req);
    chk("status_after_abort", 64'(rdata), 64'(32'h1));

    // Randomized traffic on both sides, including out-of-range addresses.
    req_mode = 2;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 4) begin
        logic [31:0] a;
        case ($urandom_range(0, 7))
          0, 1, 2: a = BASE;
          3, 4:    a = BASE + 32'h4;
          5:       a = BASE + 32'h84;
          6:       a = HIGH + 32'h1;
          default: a = BASE - 32'h4;
        endcase
        opb_xfer(a, ($urandom_range(0, 3) != 0), $urandom, $urandom_range(1, 4),
                 rdata, n_ack, first_ack, ack_req);
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
